// File: rtl/duv_mem_arb.sv
// duv_mem_arb: round-robin shared single-port memory with a post-reset clear.
// Optional ownership locking is built when DUV_MEM_ARB_LOCK_EN is defined.
module duv_mem_arb #(
    parameter int REQ_N      = 4,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int INIT_CLEAR = 1,
    parameter int LOCK_MAX   = 16
) (
    input  logic                    duv_mem_arb_clk_ip,
    input  logic                    duv_mem_arb_rst_ip,
    input  logic [REQ_N-1:0]        duv_mem_arb_req_ip,
    input  logic [REQ_N-1:0]        duv_mem_arb_we_ip,
    input  logic [REQ_N*ADDR_W-1:0] duv_mem_arb_addr_ip,
    input  logic [REQ_N*DATA_W-1:0] duv_mem_arb_wdata_ip,
    input  logic [REQ_N-1:0]        duv_mem_arb_lock_ip,
    output logic [REQ_N-1:0]        duv_mem_arb_gnt_op,
    output logic [REQ_N-1:0]        duv_mem_arb_rvalid_op,
    output logic [DATA_W-1:0]       duv_mem_arb_rdata_op,
    output logic                    duv_mem_arb_ready_op,
    output logic                    duv_mem_arb_busy_op
);

    localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   init_addr;
    logic [PTR_W-1:0]    rr_ptr;
    logic [REQ_N-1:0]    elig;
    logic                win_vld;
    logic [PTR_W-1:0]    win_idx;
    logic [REQ_N-1:0]    win_oh;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic [PTR_W:0]      scan;
    logic [REQ_N-1:0]    rd_pend;
    logic [DATA_W-1:0]   rd_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(REQ_N - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

`ifdef DUV_MEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic              own_vld;
    logic [PTR_W-1:0]  own_idx;
    logic [CNT_W-1:0]  lock_cnt;
    logic [2:0]        idle_cnt;
    logic              lock_warn;
    logic [REQ_N-1:0]  own_mask;

    // While a lock is held only the owner may compete.
    always_comb begin
        own_mask = '1;
        if (own_vld) own_mask = REQ_N'(1) << own_idx;
    end

    assign elig = duv_mem_arb_req_ip & ~duv_mem_arb_gnt_op & own_mask;
`else
    logic lock_unused;
    assign lock_unused = (^duv_mem_arb_lock_ip) ^ (LOCK_MAX > 0);
    assign elig = duv_mem_arb_req_ip & ~duv_mem_arb_gnt_op;
`endif

    // First eligible requester at or above the pointer, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        scan    = '0;
        for (int i = 0; i < REQ_N; i++) begin
            scan = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
            if (scan >= (PTR_W + 1)'(REQ_N)) scan = scan - (PTR_W + 1)'(REQ_N);
            if (!win_vld && elig[scan[PTR_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = scan[PTR_W-1:0];
            end
        end
        if (state != ST_RUN) win_vld = 1'b0;
    end

    // Route the winner's command fields to the array port.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int k = 0; k < REQ_N; k++) begin
            if (win_idx == PTR_W'(k)) begin
                win_we    = duv_mem_arb_we_ip[k];
                win_addr  = duv_mem_arb_addr_ip[k*ADDR_W +: ADDR_W];
                win_wdata = duv_mem_arb_wdata_ip[k*DATA_W +: DATA_W];
            end
        end
    end

    assign win_oh = REQ_N'(1) << win_idx;

    // Array port: clear writes during CLEAR, granted access in RUN.
    always_ff @(posedge duv_mem_arb_clk_ip) begin
        if (state == ST_CLEAR) begin
            mem[init_addr] <= '0;
        end else if (win_vld && win_we) begin
            mem[win_addr] <= win_wdata;
        end
        if (win_vld && !win_we) rd_q <= mem[win_addr];
    end

    // Sequencer, arbiter state and registered outputs.
    always_ff @(posedge duv_mem_arb_clk_ip or negedge duv_mem_arb_rst_ip) begin
        if (!duv_mem_arb_rst_ip) begin
            state                 <= ST_INIT;
            init_addr             <= '0;
            rr_ptr                <= '0;
            rd_pend               <= '0;
            duv_mem_arb_gnt_op    <= '0;
            duv_mem_arb_rvalid_op <= '0;
            duv_mem_arb_rdata_op  <= '0;
            duv_mem_arb_ready_op  <= 1'b0;
            duv_mem_arb_busy_op   <= 1'b0;
`ifdef DUV_MEM_ARB_LOCK_EN
            own_vld               <= 1'b0;
            own_idx               <= '0;
            lock_cnt              <= '0;
            idle_cnt              <= '0;
            lock_warn             <= 1'b0;
`endif
        end else begin
            duv_mem_arb_gnt_op    <= '0;
            duv_mem_arb_busy_op   <= 1'b0;
            duv_mem_arb_rvalid_op <= rd_pend;
            rd_pend               <= '0;
            if (|rd_pend) duv_mem_arb_rdata_op <= rd_q;
`ifdef DUV_MEM_ARB_LOCK_EN
            lock_warn             <= 1'b0;
`endif
            unique case (state)
                ST_INIT: begin
                    if (INIT_CLEAR != 0) begin
                        state <= ST_CLEAR;
                    end else begin
                        state                <= ST_RUN;
                        duv_mem_arb_ready_op <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    init_addr <= init_addr + ADDR_W'(1);
                    if (init_addr == '1) begin
                        state                <= ST_RUN;
                        duv_mem_arb_ready_op <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (win_vld) begin
                        duv_mem_arb_gnt_op  <= win_oh;
                        duv_mem_arb_busy_op <= 1'b1;
                        if (!win_we) rd_pend <= win_oh;
                    end
`ifdef DUV_MEM_ARB_LOCK_EN
                    if (own_vld) begin
                        if (win_vld) begin
                            idle_cnt <= '0;
                            if (!duv_mem_arb_lock_ip[own_idx]) begin
                                own_vld <= 1'b0;
                                rr_ptr  <= inc_ptr(own_idx);
                            end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
                                own_vld   <= 1'b0;
                                rr_ptr    <= inc_ptr(own_idx);
                                lock_warn <= 1'b1;
                            end else begin
                                lock_cnt <= lock_cnt + CNT_W'(1);
                            end
                        end else if (!duv_mem_arb_req_ip[own_idx]) begin
                            if (idle_cnt == 3'd7) begin
                                own_vld <= 1'b0;
                                rr_ptr  <= inc_ptr(own_idx);
                            end else begin
                                idle_cnt <= idle_cnt + 3'd1;
                            end
                        end else begin
                            idle_cnt <= '0;
                        end
                    end else if (win_vld) begin
                        if (duv_mem_arb_lock_ip[win_idx] && LOCK_MAX > 1) begin
                            own_vld  <= 1'b1;
                            own_idx  <= win_idx;
                            lock_cnt <= CNT_W'(1);
                            idle_cnt <= '0;
                        end else begin
                            rr_ptr <= inc_ptr(win_idx);
                            if (duv_mem_arb_lock_ip[win_idx]) lock_warn <= 1'b1;
                        end
                    end
`else
                    if (win_vld) rr_ptr <= inc_ptr(win_idx);
`endif
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
